key_onehot_capture: RTL and testbench
=====================================

// Module: key_onehot_capture
// PURPOSE
//  Upstream stage of the 4-to-2 encoder. Takes four raw push-button inputs and
//  synchronises and debounces each one. Each new press is captured as a one-hot
//  4-bit word and held until the encoder side accepts it through a valid/ready
//  handshake. At most one one-hot word is issued per press/release cycle.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000  stable cycles required before a debounced level changes (>=2)
//  CNT_W            10    debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk         in   1  system clock; all state is on the rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  btn_raw     in   4  raw buttons, active-high, asynchronous to clk
//  onehot_out  out  4  captured one-hot code; bit i corresponds to btn_raw[i]
//  out_valid   out  1  onehot_out holds a code not yet accepted
//  out_ready   in   1  consumer accepts the code when out_valid && out_ready
//  busy        out  1  high in HOLD and RELEASE_WAIT
// BEHAVIOUR
//  - Reset (async assert, sync release): onehot_out=0, out_valid=0, busy=0,
//    sync flops=0, debounced levels=0, counters=0, state=IDLE.
//  - Synchroniser: 2-flop chain per bit. Debounce per bit: if the synced level
//    differs from the debounced level, increment the counter; otherwise clear it.
//    When the counter reaches DEBOUNCE_CYCLES-1, flip the debounced level and clear
//    the counter. Counter saturates and never wraps. Latency from a clean edge to
//    the debounced edge is 2+DEBOUNCE_CYCLES cycles.
//  - press[i] = rising edge of debounced[i] (a one-cycle pulse).
//  - FSM IDLE: if any press, load onehot_out with the LOWEST set index of press
//    (press=4'b0110 -> 4'b0010), set out_valid=1, go to HOLD. Other presses
//    in the same cycle are discarded.
//  - FSM HOLD: out_valid=1 and onehot_out stays stable until the handshake.
//    On out_valid&&out_ready: out_valid=0 on the next edge, onehot_out=0, go to RELEASE_WAIT.
//    Presses in HOLD are ignored. No queueing.
//  - FSM RELEASE_WAIT: wait until debounced==4'b0000, then go to IDLE on the next edge.
//    A press arriving in the same cycle as the IDLE entry is not captured.
//  - out_ready while out_valid=0 has no effect. out_valid never drops without a handshake.
//  - Reset mid-HOLD: the code is lost, out_valid=0 immediately, and there is no
//    replay after release.
//  - Invariant: onehot_out is 0 or has exactly one bit set; it is non-zero only when out_valid=1.
// CONFIGURATION
//  MULTI_PRESS_ERR_EN defined:
//    - Adds output `multi_err` (out, 1), reset 0.
//    - Pulses high for one cycle when IDLE sees more than one press bit in the same cycle.
//    - The lowest index is still captured.
//  MULTI_PRESS_ERR_EN undefined:
//    - The port and its logic are absent.
//    - Behaviour is otherwise identical.
// STRUCTURE
//  - Shared header encoder_lab_defs.vh holds:
//    - FSM state codes ST_IDLE=2'd0, ST_HOLD=2'd1, ST_RELEASE_WAIT=2'd2.
//    - Default debounce constant DEF_DEBOUNCE_CYCLES=1000.
//  - Sub-module debounce_cell (clk, rst_n, raw, level, params DEBOUNCE_CYCLES/CNT_W):
//    - Contains the synchroniser, counter and level flop.
//    - Instantiated 4x by a generate loop.
//  - The top holds edge detect, priority pick, FSM and output register.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 Reset then idle with btn_raw=0 for 50 cycles -> onehot_out=0, out_valid=0, busy=0.
//  2 Hold btn_raw=4'b0100 with out_ready=1 -> onehot_out=4'b0100 with a one-cycle
//    out_valid exactly 2+4+1 cycles after the edge. No second code until release.
//  3 Toggle btn_raw[1] every 2 cycles for 40 cycles -> out_valid never asserts.
//  4 Set btn_raw=4'b1010 in one cycle -> onehot_out=4'b0010. With MULTI_PRESS_ERR_EN,
//    multi_err pulses once in the capture cycle.
//  5 out_ready=0 for 20 cycles after capture of 4'b0001 while pressing btn[3]
//    -> out_valid and the code stay stable. btn[3] is ignored. After out_ready=1,
//    one transfer occurs.
//  6 Drop rst_n mid-HOLD for 1 cycle -> out_valid=0 asynchronously. After release,
//    still-held buttons do not re-trigger until they are released and pressed again.

Source files
------------

// File: rtl/key_onehot_capture_pkg.sv
// Shared constants, FSM state codes and small helpers for the key capture front end.
package key_onehot_capture_pkg;

    localparam int NUM_KEYS            = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_CNT_W           = 10;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HOLD         = 2'd1,
        ST_RELEASE_WAIT = 2'd2
    } state_e;

    // Isolates the lowest set bit: 4'b0110 -> 4'b0010.
    function automatic logic [NUM_KEYS-1:0] lowest_onehot(input logic [NUM_KEYS-1:0] v);
        return v & (~v + NUM_KEYS'(1));
    endfunction

    function automatic logic more_than_one(input logic [NUM_KEYS-1:0] v);
        return (v & (v - NUM_KEYS'(1))) != '0;
    endfunction

endpackage

// File: rtl/key_onehot_capture_debounce.sv
// debounce_cell: two-flop synchroniser followed by a stable-count debouncer for one button.
module debounce_cell
    import key_onehot_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= raw;
            r_sync1 <= r_sync0;
            if (r_sync1 != r_level) begin
                if (r_cnt >= CNT_LAST) begin
                    r_level <= r_sync1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/key_onehot_capture.sv
// Debounced push-button capture: issues one one-hot code per press over valid/ready.
// Optional MULTI_PRESS_ERR_EN adds a multi_err pulse when several keys are seen at once.
module key_onehot_capture
    import key_onehot_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] onehot_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
`ifdef MULTI_PRESS_ERR_EN
    ,
    output logic       multi_err
`endif
);

    localparam int               SETTLE_CYCLES = DEBOUNCE_CYCLES + 3;
    localparam logic [CNT_W:0]   SETTLE_LAST   = (CNT_W+1)'(SETTLE_CYCLES);

    logic [3:0]     w_debounced;
    logic [3:0]     w_press;
    logic [3:0]     r_level_d;
    logic [3:0]     r_blocked;
    logic [CNT_W:0] r_settle_cnt;
    logic           w_settled;
    state_e         r_state;
    state_e         w_state_nxt;
    logic [3:0]     r_onehot;
    logic [3:0]     w_onehot_nxt;
    logic           r_valid;
    logic           w_valid_nxt;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_deb
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[gi]),
            .level (w_debounced[gi])
        );
    end

    // Keys already held when reset releases would otherwise debounce into a fresh press;
    // each key stays blocked until it has been seen released after the settle window.
    assign w_settled = (r_settle_cnt == SETTLE_LAST);
    assign w_press   = w_debounced & ~r_level_d & ~r_blocked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d    <= '0;
            r_blocked    <= '1;
            r_settle_cnt <= '0;
        end else begin
            r_level_d <= w_debounced;
            if (!w_settled) begin
                r_settle_cnt <= r_settle_cnt + (CNT_W+1)'(1);
            end else begin
                r_blocked <= r_blocked & w_debounced;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_onehot <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_onehot <= w_onehot_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_onehot_nxt = r_onehot;
        w_valid_nxt  = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_press != '0) begin
                    w_onehot_nxt = lowest_onehot(w_press);
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_valid && out_ready) begin
                    w_onehot_nxt = '0;
                    w_valid_nxt  = 1'b0;
                    w_state_nxt  = ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_debounced == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_onehot_nxt = '0;
                w_valid_nxt  = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    assign onehot_out = r_onehot;
    assign out_valid  = r_valid;
    assign busy       = (r_state != ST_IDLE);

`ifdef MULTI_PRESS_ERR_EN
    logic r_multi_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi_err <= 1'b0;
        end else begin
            r_multi_err <= (r_state == ST_IDLE) && more_than_one(w_press);
        end
    end

    assign multi_err = r_multi_err;
`endif

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with DEBOUNCE_CYCLES=4 (capture 7 cycles after a clean edge).
module tb_key_onehot_capture;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] onehot_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef MULTI_PRESS_ERR_EN
    logic       multi_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    key_onehot_capture #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .onehot_out (onehot_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef MULTI_PRESS_ERR_EN
        ,
        .multi_err  (multi_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Invariant: code is zero or one-hot, and non-zero only while valid.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("onehot_invariant",
                  8'(((onehot_out & (onehot_out - 4'd1)) == 4'd0) &&
                     (onehot_out == 4'd0 || out_valid)), 8'd1);
        end
    end

    typedef struct {
        logic [3:0] btn;
        int         steps;
        logic [3:0] exp_oh;
        logic       exp_v;
        logic       exp_busy;
        logic       exp_multi;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Single-key capture with ready high, then release; then a two-key press.
        vecs[0] = '{4'b0100,  6, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0100,  1, 4'b0100, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{4'b0100,  1, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'b0100, 20, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'b0000,  6, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'b0000,  1, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'b1010,  6, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{4'b1010,  1, 4'b0010, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{4'b1010,  1, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{4'b0000,  7, 4'b0000, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        btn_raw   = 4'b0000;
        out_ready = 1'b0;
        step(3);
        check("reset_valid", 8'(out_valid), 8'd0);
        check("reset_onehot", 8'(onehot_out), 8'd0);
        check("reset_busy", 8'(busy), 8'd0);
        rst_n = 1'b1;

        step(50);
        check("idle_valid", 8'(out_valid), 8'd0);
        check("idle_onehot", 8'(onehot_out), 8'd0);
        check("idle_busy", 8'(busy), 8'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn_raw = vecs[i].btn;
            step(vecs[i].steps);
            check($sformatf("vec%0d_onehot", i), 8'(onehot_out), 8'(vecs[i].exp_oh));
            check($sformatf("vec%0d_valid", i), 8'(out_valid), 8'(vecs[i].exp_v));
            check($sformatf("vec%0d_busy", i), 8'(busy), 8'(vecs[i].exp_busy));
`ifdef MULTI_PRESS_ERR_EN
            check($sformatf("vec%0d_multi_err", i), 8'(multi_err), 8'(vecs[i].exp_multi));
`endif
        end

        // Bouncing key: level never stable for 4 cycles, so nothing is captured.
        for (int c = 0; c < 40; c++) begin
            btn_raw = (((c >> 1) & 1) == 0) ? 4'b0010 : 4'b0000;
            step(1);
            check("bounce_no_valid", 8'(out_valid), 8'd0);
        end
        btn_raw = 4'b0000;
        step(10);
        check("bounce_busy", 8'(busy), 8'd0);

        // Backpressure: code held stable, a second key is ignored, one transfer on ready.
        out_ready = 1'b0;
        btn_raw   = 4'b0001;
        step(7);
        check("bp_capture_valid", 8'(out_valid), 8'd1);
        check("bp_capture_onehot", 8'(onehot_out), 8'h01);
        btn_raw = 4'b1001;
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("bp_hold_valid", 8'(out_valid), 8'd1);
            check("bp_hold_onehot", 8'(onehot_out), 8'h01);
        end
        out_ready = 1'b1;
        step(1);
        check("bp_xfer_valid", 8'(out_valid), 8'd0);
        check("bp_xfer_busy", 8'(busy), 8'd1);
        for (int c = 0; c < 10; c++) begin
            step(1);
            check("bp_no_second", 8'(out_valid), 8'd0);
        end
        btn_raw = 4'b0000;
        step(7);
        check("bp_release_busy", 8'(busy), 8'd0);

        // Reset during HOLD: valid drops at once; held key needs release and a new press.
        out_ready = 1'b0;
        btn_raw   = 4'b0100;
        step(7);
        check("rst_hold_valid", 8'(out_valid), 8'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 8'(out_valid), 8'd0);
        check("rst_async_onehot", 8'(onehot_out), 8'd0);
        check("rst_async_busy", 8'(busy), 8'd0);
        step(1);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step(1);
            check("rst_no_replay", 8'(out_valid), 8'd0);
        end
        btn_raw = 4'b0000;
        step(15);
        check("rst_released_busy", 8'(busy), 8'd0);
        btn_raw = 4'b0100;
        step(6);
        check("repress_early", 8'(out_valid), 8'd0);
        step(1);
        check("repress_valid", 8'(out_valid), 8'd1);
        check("repress_onehot", 8'(onehot_out), 8'h04);
        out_ready = 1'b1;
        step(1);
        check("repress_xfer", 8'(out_valid), 8'd0);
        btn_raw = 4'b0000;
        step(10);
        check("final_busy", 8'(busy), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
